// File: rtl/tdm_demux16.sv
// Receive side of a 16-slot TDM link: tracks the slot counter, steers each inverted
// serial bit into a shadow register and publishes a full 16-bit frame on slot 15.
module tdm_demux16 #(
  parameter int unsigned SYNC_EVERY_FRAME = 1,
  parameter int unsigned CHANNELS         = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  input  logic        en,
  input  logic        sync,
  input  logic        strobe,
  output logic [15:0] F,
  output logic        frame_valid,
  output logic [3:0]  sel,
  output logic        locked,
  output logic        sync_err
);

  localparam int unsigned LastSlot = CHANNELS - 1;
  localparam logic [3:0]  LastSel  = LastSlot[3:0];

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [14:0] shadow_q, shadow_d;
  logic [15:0] f_q, f_d;
  logic        fv_q, fv_d;
  logic        err_q, err_d;
  logic        slot_bit;

  // Blanked slots read as 0; otherwise the line is active-low.
  assign slot_bit = strobe ? 1'b0 : ~din;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    f_d      = f_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;
    if (en) begin
      unique case (state_q)
        StHunt: begin
          if (sync) begin
            shadow_d[0] = slot_bit;
            sel_d       = 4'd1;
            state_d     = StLocked;
          end
        end
        StLocked: begin
          if (sync) begin
            // Sync wins over slot-15 completion; a mid-frame sync drops the partial frame.
            err_d       = (sel_q != 4'd0);
            shadow_d[0] = slot_bit;
            sel_d       = 4'd1;
          end else if (sel_q == 4'd0) begin
            if (SYNC_EVERY_FRAME != 0) begin
              err_d   = 1'b1;
              state_d = StHunt;
            end else begin
              shadow_d[0] = slot_bit;
              sel_d       = 4'd1;
            end
          end else if (sel_q == LastSel) begin
            f_d   = {slot_bit, shadow_q};
            fv_d  = 1'b1;
            sel_d = 4'd0;
          end else begin
            shadow_d[sel_q] = slot_bit;
            sel_d           = sel_q + 4'd1;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StHunt;
      sel_q    <= 4'd0;
      shadow_q <= 15'd0;
      f_q      <= 16'd0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      f_q      <= f_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
    end
  end

  assign F           = f_q;
  assign frame_valid = fv_q;
  assign sel         = sel_q;
  assign locked      = (state_q == StLocked);
  assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux16.sv
// Directed and randomized frame-level checks of tdm_demux16 in both sync modes.
module tb_tdm_demux16;

  logic        clk = 1'b0;
  logic        rst_n, din, en, sync, strobe;
  logic [15:0] f_s, f_f;
  logic        fv_s, fv_f, lk_s, lk_f, er_s, er_f;
  logic [3:0]  sel_s, sel_f;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  tdm_demux16 #(.SYNC_EVERY_FRAME(1)) u_strict (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .sync(sync), .strobe(strobe),
    .F(f_s), .frame_valid(fv_s), .sel(sel_s), .locked(lk_s), .sync_err(er_s)
  );

  tdm_demux16 #(.SYNC_EVERY_FRAME(0)) u_free (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .sync(sync), .strobe(strobe),
    .F(f_f), .frame_valid(fv_f), .sel(sel_f), .locked(lk_f), .sync_err(er_f)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic d, input logic s, input logic st);
    en = 1'b1; din = d; sync = s; strobe = st;
    tick();
    en = 1'b0; din = 1'b1; sync = 1'b0; strobe = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Sends one synced frame; both DUTs are expected to behave identically.
  task automatic send_frame(input logic [15:0] word, input logic [15:0] mask, input int max_gap);
    logic [15:0] exp;
    int          g;
    exp = word & ~mask;
    for (int i = 0; i < 16; i++) begin
      if (max_gap > 0 && i > 0) begin
        g = $urandom_range(max_gap, 0);
        repeat (g) tick();
        if (g > 0) begin
          chk("gap_sel", {12'd0, sel_s}, 16'(i));
          chk("gap_fv", {15'd0, fv_s}, 16'd0);
        end
      end
      slot(~word[i], i == 0, mask[i]);
      chk("fv_strict", {15'd0, fv_s}, 16'(i == 15));
      chk("fv_free", {15'd0, fv_f}, 16'(i == 15));
      chk("sel", {12'd0, sel_s}, 16'((i + 1) % 16));
      chk("err", {15'd0, er_s | er_f}, 16'd0);
    end
    chk("F_strict", f_s, exp);
    chk("F_free", f_f, exp);
    chk("locked", {14'd0, lk_s, lk_f}, 16'h3);
  endtask

  initial begin
    logic [15:0] w, m, prev;
    rst_n = 1'b0; din = 1'b1; en = 1'b0; sync = 1'b0; strobe = 1'b0;
    repeat (2) tick();
    chk("rst_F", f_s, 16'h0);
    chk("rst_sel", {12'd0, sel_s}, 16'h0);
    chk("rst_flags", {12'd0, fv_s, lk_s, er_s, lk_f}, 16'h0);
    rst_n = 1'b1;
    tick();

    send_frame(16'hA5C3, 16'h0000, 0);
    tick();
    chk("fv_one_cycle", {15'd0, fv_s}, 16'd0);
    send_frame(16'hFFFF, 16'h1008, 0);
    chk("strobe_F", f_s, 16'hEFF7);
    send_frame(16'h1234, 16'h0000, 5);

    // Mid-frame sync at slot 7 restarts the frame without touching F.
    for (int i = 0; i < 7; i++) slot(1'b0, i == 0, 1'b0);
    slot(1'b0, 1'b1, 1'b0);
    chk("prem_err", {14'd0, er_s, er_f}, 16'h3);
    chk("prem_sel", {12'd0, sel_s}, 16'd1);
    chk("prem_F", f_s, 16'h1234);
    chk("prem_fv", {15'd0, fv_s}, 16'd0);
    for (int i = 1; i < 16; i++) begin
      slot(1'b0, 1'b0, 1'b0);
      chk("prem_err_clr", {15'd0, er_s}, 16'd0);
      chk("prem_fv_i", {15'd0, fv_s}, 16'(i == 15));
    end
    chk("prem_F_new", f_s, 16'hFFFF);

    send_frame(16'h00FF, 16'h0000, 0);
    w = 16'h3C5A;
    for (int i = 0; i < 16; i++) begin
      slot(~w[i], 1'b0, 1'b0);
      chk("miss_err_s", {15'd0, er_s}, 16'(i == 0));
      chk("miss_err_f", {15'd0, er_f}, 16'd0);
      chk("miss_lk_s", {15'd0, lk_s}, 16'd0);
      chk("miss_sel_s", {12'd0, sel_s}, 16'd0);
      chk("miss_fv_f", {15'd0, fv_f}, 16'(i == 15));
    end
    chk("miss_F_s", f_s, 16'h00FF);
    chk("miss_F_f", f_f, w);
    do_reset();

    for (int n = 0; n < 20; n++) begin
      w = 16'($urandom);
      m = ($urandom_range(3, 0) == 0) ? 16'($urandom) : 16'h0;
      send_frame(w, m, $urandom_range(3, 0));
    end

    // Asynchronous reset between edges in the middle of a frame.
    prev = f_s;
    for (int i = 0; i < 9; i++) slot(1'b0, i == 0, 1'b0);
    chk("pre_rst_F", f_s, prev);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_F", f_s | f_f, 16'h0);
    chk("arst_sel", {12'd0, sel_s}, 16'h0);
    chk("arst_lk", {14'd0, lk_s, lk_f}, 16'h0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      slot(1'b0, 1'b0, 1'b0);
      chk("post_rst_sel", {12'd0, sel_s | sel_f}, 16'h0);
      chk("post_rst_flags", {12'd0, fv_s | fv_f, lk_s | lk_f, er_s, er_f}, 16'h0);
    end
    chk("post_rst_F", f_s | f_f, 16'h0);
    send_frame(16'hBEEF, 16'h0000, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux16.md
Name: tdm_demux16

Overview:
- Receive end of a 16-channel time-division link whose transmit end is a 16:1 selector.
- The transmitter emits an active-low serial bit per slot, gated by a strobe, in channel order 0..15 with a sync marker on slot 0.
- This block tracks the slot counter, inverts and steers each bit to its channel, and presents a double-buffered 16-bit parallel word once per complete frame.

Parameters:
- SYNC_EVERY_FRAME, 1, 1 = sync required on every slot 0 (missing sync is an error); 0 = free-running after first lock.
- CHANNELS, 16, number of slots per frame; fixed at 16 (counter is 4 bits), present for documentation and checking only.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- din  in  1  serial slot data, active-low (channel value = ~din)
- en  in  1  slot-valid; a slot is consumed only on a clk edge with en=1
- sync  in  1  frame marker, qualified by en; high marks the slot as channel 0
- strobe  in  1  transmitter strobe; high = slot blanked, captured value forced to 0
- F  out  16  last complete frame, F[n] = channel n
- frame_valid  out  1  one-cycle pulse, high in the cycle F updates
- sel  out  4  channel index the next consumed slot will be written to
- locked  out  1  high in LOCKED state
- sync_err  out  1  one-cycle pulse on framing error

Behaviour:
- Reset (async, rst_n=0):
  - F=0, shadow=0, sel=0, frame_valid=0, sync_err=0, locked=0, state=HUNT.
  - Deassertion takes effect at the next edge.
- Slot value: bit = strobe ? 0 : ~din.
- en=0:
  - All state, sel, shadow and F hold.
  - frame_valid and sync_err are 0.
- Pulses: frame_valid and sync_err are registered and high for exactly the one cycle after the triggering edge.
- HUNT:
  - en=1 with sync=0: ignored, no capture.
  - en=1 with sync=1: shadow[0]<=bit, sel<=1, go LOCKED.
- LOCKED, en=1:
  - sync=1 and sel==0: normal frame start; shadow[0]<=bit, sel<=1.
  - sync=1 and sel!=0: premature sync.
    - sync_err pulse, partial frame discarded (F unchanged).
    - shadow[0]<=bit, sel<=1, remain LOCKED.
  - sync=0 and sel==0:
    - SYNC_EVERY_FRAME=1: missing sync. sync_err pulse, no capture, go HUNT, sel stays 0.
    - SYNC_EVERY_FRAME=0: treat as normal frame start (capture into shadow[0], sel<=1).
  - sync=0 and 1<=sel<=14: shadow[sel]<=bit, sel<=sel+1.
  - sync=0 and sel==15:
    - F<={bit, shadow[14:0]}, frame_valid pulse, sel wraps to 0.
    - shadow is not cleared; every slot is overwritten each frame.
- Frame latency: F reflects slot 15 on the edge that consumes slot 15. Minimum frame_valid spacing is 16 en-cycles.
- Simultaneous events: in a sync=1 cycle the sync rules above take precedence over the sel==15 completion, so no frame_valid fires.
- Reset mid-frame: shadow content is lost, F clears to 0, next frame requires sync (HUNT).
- Completed F holds until the next complete frame; error paths never modify F.
- locked = (state==LOCKED), registered.

Test Plan:
- Reset then clean frame: sync+en on slot 0, 16 consecutive en slots with din = ~16'hA5C3 (LSB first), strobe=0.
  - frame_valid pulses once after slot 15, F=16'hA5C3, sel=0, locked=1.
- Strobe blanking: same frame with strobe=1 on slots 3 and 12, all din=0.
  - F=16'hEFF7.
- Gapped en: insert 0-5 idle (en=0) cycles between slots of frame 16'h1234.
  - F=16'h1234, frame_valid only after the 16th en slot, sel holds during gaps.
- Premature sync: sync asserted at slot 7 of frame 2.
  - sync_err pulse, F keeps frame 1 value, the following full frame 16'hFFFF delivers F=16'hFFFF.
- Missing sync, SYNC_EVERY_FRAME=1: frame 16'h00FF ends, next slot has en=1, sync=0.
  - sync_err pulse, locked=0, further non-sync slots ignored, F stays 16'h00FF. With SYNC_EVERY_FRAME=0 the same stimulus gives no error and the next frame completes.
- Async reset at slot 9: assert rst_n=0 between edges.
  - F=0, sel=0, locked=0 immediately. Post-reset slots without sync give no capture.
